// File: rtl/nibble_io_bridge.sv
// nibble_io_bridge: bridges a CPU's toggle-strobed nibble ports to byte-wide valid/ready host streams.
module nibble_io_bridge #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Out0,
  input  logic [3:0] Out1,
  output logic [3:0] In0,
  output logic [3:0] In1,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {W_HI, W_LO} w_t;
  typedef enum logic [1:0] {R_EMPTY, R_HI, R_LO} r_t;
  w_t w_st, w_nx;
  r_t r_st, r_nx;
  logic [3:0] o0_r, hi_r;
  logic [1:0] o1_r, p1_r;
  logic clr_r, err_r, err_set, unused_ok;
  logic [7:0] hold_r;
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
  logic [AW:0] tx_cnt, rx_cnt;
  logic wstb, rack, tx_full, rx_full, rx_ne;
  logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  assign unused_ok = Out1[2];
  // Toggles are edges of the registered control bits; soft clear discards them.
  assign wstb = (o1_r[0] ^ p1_r[0]) & ~clr_r;
  assign rack = (o1_r[1] ^ p1_r[1]) & ~clr_r;
  assign tx_full = tx_cnt == FULL;
  assign rx_full = rx_cnt == FULL;
  assign rx_ne = rx_cnt != '0;
  assign tx_valid = tx_cnt != '0;
  assign tx_data = tx_valid ? tx_mem[tx_rd] : 8'h00;
  assign tx_pop = tx_valid & tx_ready;
  assign tx_push_req = wstb & (w_st == W_LO);
  assign tx_push = tx_push_req & (~tx_full | tx_pop);
  assign rx_ready = ~rx_full & ~reset & ~clr_r;
  assign rx_push = rx_valid & rx_ready;
  always_comb begin
    w_nx = wstb ? (w_st == W_HI ? W_LO : W_HI) : w_st;
    r_nx = r_st;
    rx_pop = 1'b0;
    err_set = tx_push_req & ~tx_push;
    case (r_st)
      R_EMPTY: begin
        rx_pop = rx_ne;
        r_nx = rx_ne ? R_HI : R_EMPTY;
        err_set = err_set | rack;
      end
      R_HI: r_nx = rack ? R_LO : R_HI;
      R_LO: begin
        rx_pop = rack & rx_ne;
        r_nx = rack ? (rx_ne ? R_HI : R_EMPTY) : R_LO;
      end
      default: r_nx = R_EMPTY;
    endcase
    In0 = r_st == R_HI ? hold_r[7:4] : r_st == R_LO ? hold_r[3:0] : 4'h0;
    In1 = {err_r, tx_full, r_st == R_LO, r_st != R_EMPTY};
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= {hi_r, o0_r};
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      o0_r <= '0;
      o1_r <= '0;
      p1_r <= '0;
      clr_r <= 1'b0;
      w_st <= W_HI;
      r_st <= R_EMPTY;
      hi_r <= '0;
      hold_r <= '0;
      err_r <= 1'b0;
      tx_rd <= '0;
      tx_wr <= '0;
      tx_cnt <= '0;
      rx_rd <= '0;
      rx_wr <= '0;
      rx_cnt <= '0;
    end else begin
      o0_r <= Out0;
      o1_r <= Out1[1:0];
      p1_r <= o1_r;
      clr_r <= Out1[3];
      if (clr_r) begin
        w_st <= W_HI;
        r_st <= R_EMPTY;
        hold_r <= '0;
        err_r <= 1'b0;
        tx_rd <= '0;
        tx_wr <= '0;
        tx_cnt <= '0;
        rx_rd <= '0;
        rx_wr <= '0;
        rx_cnt <= '0;
      end else begin
        w_st <= w_nx;
        r_st <= r_nx;
        err_r <= err_r | err_set;
        if (wstb && w_st == W_HI) hi_r <= o0_r;
        if (rx_pop) hold_r <= rx_mem[rx_rd];
        if (tx_push) tx_wr <= tx_wr + AW'(1);
        if (tx_pop) tx_rd <= tx_rd + AW'(1);
        if (rx_push) rx_wr <= rx_wr + AW'(1);
        if (rx_pop) rx_rd <= rx_rd + AW'(1);
        tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      end
    end
  end
endmodule

// File: tb/tb_nibble_io_bridge.sv
// tb_nibble_io_bridge: randomized CPU/host operations checked against a queue-based model.
module tb_nibble_io_bridge;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] Out0 = '0, Out1 = '0, In0, In1;
  logic [7:0] tx_data, rx_data = '0;
  logic tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready;
  int total = 0, bad = 0;
  logic [7:0] tx_q[$], rx_q[$];
  int rs = 0;
  logic [7:0] hold = '0;
  logic half_v = 1'b0, err = 1'b0;
  logic [3:0] half_n = '0, out1 = '0;

  nibble_io_bridge #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .Out0(Out0), .Out1(Out1), .In0(In0), .In1(In1),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic normalize();
    if (rs == 0 && rx_q.size() > 0) begin
      hold = rx_q.pop_front();
      rs = 1;
    end
  endtask

  task automatic check_all();
    logic [3:0] e0;
    e0 = rs == 1 ? hold[7:4] : rs == 2 ? hold[3:0] : 4'h0;
    chk("in0", In0, e0);
    chk("in1", In1, {err, tx_q.size() == 4, rs == 2, rs != 0});
    chk("tx_valid", tx_valid, tx_q.size() != 0);
    chk("tx_data", tx_data, tx_q.size() != 0 ? tx_q[0] : 8'h00);
    chk("rx_ready", rx_ready, rx_q.size() < 4);
  endtask

  task automatic wr_nib(input logic [3:0] n);
    Out0 = n;
    tick(1);
    out1[0] = ~out1[0];
    Out1 = out1;
    tick(3);
    if (!half_v) begin
      half_n = n;
      half_v = 1'b1;
    end else begin
      if (tx_q.size() < 4) tx_q.push_back({half_n, n});
      else err = 1'b1;
      half_v = 1'b0;
    end
  endtask

  task automatic rack();
    logic nobub, dropped;
    nobub = rs == 2 && rx_q.size() > 0;
    dropped = 1'b0;
    out1[1] = ~out1[1];
    Out1 = out1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (!In1[0]) dropped = 1'b1;
    end
    if (nobub) chk("no_bubble", dropped, 1'b0);
    if (rs == 0) err = 1'b1;
    else if (rs == 1) rs = 2;
    else if (rx_q.size() > 0) begin
      hold = rx_q.pop_front();
      rs = 1;
    end else rs = 0;
    normalize();
  endtask

  task automatic hpush(input logic [7:0] b);
    logic ok;
    ok = rx_q.size() < 4;
    rx_data = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(2);
    if (ok) rx_q.push_back(b);
    normalize();
  endtask

  task automatic hpop();
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    if (tx_q.size() > 0) void'(tx_q.pop_front());
  endtask

  task automatic soft_clr();
    out1[3] = 1'b1;
    Out1 = out1;
    tick(1);
    out1[3] = 1'b0;
    Out1 = out1;
    tick(2);
    tx_q.delete();
    rx_q.delete();
    rs = 0;
    hold = '0;
    half_v = 1'b0;
    err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out1 = '0;
    Out1 = '0;
    Out0 = '0;
    tx_ready = 1'b0;
    tick(1);
    chk("rst_in0", In0, 8'h0);
    chk("rst_in1", In1, 8'h0);
    chk("rst_txv", tx_valid, 8'h0);
    chk("rst_txd", tx_data, 8'h0);
    chk("rst_rxr", rx_ready, 8'h0);
    reset = 1'b0;
    tx_q.delete();
    rx_q.delete();
    rs = 0;
    hold = '0;
    half_v = 1'b0;
    err = 1'b0;
    tick(1);
    check_all();
  endtask

  initial begin
    tick(2);
    do_reset();
    wr_nib(4'hA);
    wr_nib(4'h5);
    check_all();
    hpop();
    check_all();
    for (int i = 0; i < 5; i++) begin
      wr_nib(4'($urandom));
      wr_nib(4'($urandom));
      check_all();
    end
    for (int i = 0; i < 4; i++) begin
      check_all();
      hpop();
    end
    check_all();
    hpush(8'h3C);
    check_all();
    rack();
    check_all();
    rack();
    check_all();
    hpush(8'h12);
    hpush(8'h34);
    for (int i = 0; i < 4; i++) begin
      check_all();
      rack();
    end
    check_all();
    wr_nib(4'h9);
    hpush(8'hE7);
    hpush(8'h81);
    soft_clr();
    check_all();
    wr_nib(4'h6);
    wr_nib(4'hD);
    check_all();
    wr_nib(4'h7);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 40);
      if (op < 12) wr_nib(4'($urandom));
      else if (op < 21) rack();
      else if (op < 30) hpush(8'($urandom));
      else if (op < 38) hpop();
      else if (op < 40) soft_clr();
      else do_reset();
      check_all();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
